// File: rtl/div_scheduler.sv
// div_scheduler: shares one external multi-cycle divider among THREADS
// requesters. Requests are granted round-robin, operands are latched at
// grant, and each request gets exactly one response pulse.
//
// Handshake: a thread raises req_valid[t] with its operands and holds it
// (operands included) until it sees resp_valid[t]. That one-cycle pulse
// marks completion. While the request stays high afterwards the thread is
// not served again; it must drop req_valid[t] for at least one cycle to
// re-arm. The divider side is a one-cycle div_start pulse, operands held
// until completion, and a div_done level that is only looked at in WAIT.
module div_scheduler #(
  parameter int N       = 8,
  parameter int THREADS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [THREADS-1:0]   req_valid,
  input  logic [THREADS*N-1:0] req_dividend,
  input  logic [THREADS*N-1:0] req_divisor,
  output logic [THREADS-1:0]   resp_valid,
  output logic [THREADS*N-1:0] resp_result,
  output logic                 busy,
  output logic                 div_start,
  output logic [N-1:0]         div_dividend,
  output logic [N-1:0]         div_divisor,
  input  logic [N-1:0]         div_result,
  input  logic                 div_done,
  output logic [1:0]           dbg_state
);

  localparam int PW = (THREADS > 1) ? $clog2(THREADS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state_q;
  logic [PW-1:0]        rr_ptr_q;
  logic [PW-1:0]        grant_q;
  logic [THREADS-1:0]   served_q;
  logic [THREADS-1:0]   served_d;
  logic [N-1:0]         opa_q;
  logic [N-1:0]         opb_q;
  logic                 div_start_q;
  logic [THREADS-1:0]   resp_valid_q;
  logic [THREADS*N-1:0] resp_result_q;

  logic [THREADS-1:0]   eligible;
  logic                 grant_found_d;
  logic [PW-1:0]        grant_d;
  logic [PW-1:0]        rr_ptr_d;
  logic [N-1:0]         sel_dividend;
  logic [N-1:0]         sel_divisor;

  // Round-robin search: first eligible thread at or after rr_ptr, wrapping.
  always_comb begin : grant_search
    int            idx;
    logic [PW-1:0] idx_p;
    eligible      = req_valid & ~served_q;
    grant_found_d = 1'b0;
    grant_d       = '0;
    idx           = 0;
    idx_p         = '0;
    for (int k = 0; k < THREADS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= THREADS) idx = idx - THREADS;
      idx_p = PW'(idx);
      if (!grant_found_d && eligible[idx_p]) begin
        grant_found_d = 1'b1;
        grant_d       = idx_p;
      end
    end
  end

  // Operands of the candidate thread and the pointer value after granting it.
  always_comb begin
    sel_dividend = req_dividend[int'(grant_d)*N +: N];
    sel_divisor  = req_divisor[int'(grant_d)*N +: N];
    rr_ptr_d     = (grant_d == PW'(THREADS - 1)) ? '0 : grant_d + 1'b1;
  end

  // A thread becomes served on leaving RESP; dropping its request re-arms it.
  always_comb begin
    served_d = served_q;
    if (state_q == S_RESP) served_d[grant_q] = 1'b1;
    served_d = served_d & req_valid;
  end

  // Scheduler FSM with registered divider and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      served_q      <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      div_start_q   <= 1'b0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
    end else begin
      served_q     <= served_d;
      div_start_q  <= 1'b0;
      resp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_found_d) begin
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            opa_q    <= sel_dividend;
            opb_q    <= sel_divisor;
            if (sel_divisor != '0) begin
              state_q     <= S_ISSUE;
              div_start_q <= 1'b1;
            end else begin
              // Divide by zero answers all-ones without touching the divider.
              state_q                            <= S_RESP;
              resp_valid_q                       <= THREADS'(1) << grant_d;
              resp_result_q[int'(grant_d)*N +: N] <= '1;
            end
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (div_done) begin
            state_q                            <= S_RESP;
            resp_valid_q                       <= THREADS'(1) << grant_q;
            resp_result_q[int'(grant_q)*N +: N] <= div_result;
          end
        end
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign div_start    = div_start_q;
  assign div_dividend = opa_q;
  assign div_divisor  = opb_q;
  assign resp_valid   = resp_valid_q;
  assign resp_result  = resp_result_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_div_scheduler.sv
// Testbench for div_scheduler: directed vector table for single requests,
// plus hand-written sequences for burst, held request, fairness and reset.
module tb_div_scheduler;

  localparam int N       = 8;
  localparam int THREADS = 4;
  localparam int W       = 3 + N;
  localparam int DLAT    = 3;

  logic                 clk;
  logic                 reset;
  logic [THREADS-1:0]   req_valid;
  logic [THREADS*N-1:0] req_dividend;
  logic [THREADS*N-1:0] req_divisor;
  logic [THREADS-1:0]   resp_valid;
  logic [THREADS*N-1:0] resp_result;
  logic                 busy;
  logic                 div_start;
  logic [N-1:0]         div_dividend;
  logic [N-1:0]         div_divisor;
  logic [N-1:0]         div_result;
  logic                 div_done;
  logic [1:0]           dbg_state;

  div_scheduler #(.N(N), .THREADS(THREADS)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .resp_valid   (resp_valid),
    .resp_result  (resp_result),
    .busy         (busy),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_result   (div_result),
    .div_done     (div_done),
    .dbg_state    (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External divider: done after DLAT wait cycles, low right after div_start
  int           dm_cnt;
  logic [N-1:0] dm_res;
  always @(posedge clk) begin
    if (reset) begin
      dm_cnt <= 0;
      dm_res <= '0;
    end else if (div_start) begin
      dm_cnt <= DLAT;
      dm_res <= (div_divisor != 0) ? div_dividend / div_divisor : '1;
    end else if (dm_cnt > 0) begin
      dm_cnt <= dm_cnt - 1;
    end
  end
  assign div_done   = (dm_cnt == 1);
  assign div_result = dm_res;

  // Monitor: records responses and divider starts
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           start_cnt = 0;
  int           ovl_err   = 0;
  int           multi_err = 0;
  bit           outstanding = 1'b0;
  logic [N-1:0] last_a = '0;
  logic [N-1:0] last_b = '0;

  always @(negedge clk) begin
    if (reset) begin
      outstanding = 1'b0;
    end else begin
      if (div_start) begin
        if (outstanding) ovl_err++;
        outstanding = 1'b1;
        start_cnt++;
        last_a = div_dividend;
        last_b = div_divisor;
      end
      if ($countones(resp_valid) > 1) multi_err++;
      for (int t = 0; t < THREADS; t++) begin
        if (resp_valid[t]) begin
          got_q.push_back({3'(t), resp_result[t*N +: N]});
          outstanding = 1'b0;
        end
      end
    end
  end

  // Scoreboard
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drain(input string name);
    logic [W-1:0] g;
    logic [W-1:0] e;
    @(negedge clk);
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s unexpected: got thread %0d result %0d expected none", name, g[W-1:N], g[N-1:0]);
      end else begin
        e = exp_q.pop_front();
        check({name, " resp {thread,result}"}, 32'(g), 32'(e));
      end
    end
    check({name, " pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_ops(input int t, input logic [N-1:0] a, input logic [N-1:0] b);
    req_dividend[t*N +: N] = a;
    req_divisor[t*N +: N]  = b;
  endtask

  // Waits for resp_valid[t] (bounded); drops the request when it arrives
  task automatic wait_resp(input int t, input int bound, output int lat);
    bit found;
    found = 1'b0;
    lat   = 0;
    while (!found && lat < bound) begin
      @(negedge clk);
      lat++;
      if (resp_valid[t]) found = 1'b1;
    end
    req_valid[t] = 1'b0;
    if (!found) lat = -1;
  endtask

  typedef struct {
    int         t;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int s0;
    int rem0;
    int rem3;
    int cyc;
    int got_n;

    vecs[0] = '{t: 2, a: 8'd200, b: 8'd7,   exp: 8'd28,  lat: 5};
    vecs[1] = '{t: 1, a: 8'd55,  b: 8'd0,   exp: 8'd255, lat: 1};
    vecs[2] = '{t: 0, a: 8'd255, b: 8'd1,   exp: 8'd255, lat: 5};
    vecs[3] = '{t: 3, a: 8'd7,   b: 8'd9,   exp: 8'd0,   lat: 5};
    vecs[4] = '{t: 1, a: 8'd0,   b: 8'd5,   exp: 8'd0,   lat: 5};
    vecs[5] = '{t: 3, a: 8'd255, b: 8'd255, exp: 8'd1,   lat: 5};
    vecs[6] = '{t: 0, a: 8'd128, b: 8'd16,  exp: 8'd8,   lat: 5};
    vecs[7] = '{t: 2, a: 8'd99,  b: 8'd0,   exp: 8'd255, lat: 1};

    reset        = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    do_reset();

    // Reset state
    check("rst resp_valid", resp_valid, 0);
    check("rst resp_result", resp_result, 0);
    check("rst div_start", div_start, 0);
    check("rst div_dividend", div_dividend, 0);
    check("rst div_divisor", div_divisor, 0);
    check("rst busy", busy, 0);
    check("rst state", dbg_state, 0);

    // Single-request vector table
    for (int i = 0; i < 8; i++) begin
      s0 = start_cnt;
      @(negedge clk);
      exp_q.push_back({3'(vecs[i].t), vecs[i].exp});
      set_ops(vecs[i].t, vecs[i].a, vecs[i].b);
      req_valid[vecs[i].t] = 1'b1;
      wait_resp(vecs[i].t, 30, lat);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d div_start count", i), start_cnt - s0, (vecs[i].b != 0) ? 1 : 0);
      if (vecs[i].b != 0) begin
        check($sformatf("vec%0d op dividend", i), last_a, vecs[i].a);
        check($sformatf("vec%0d op divisor", i), last_b, vecs[i].b);
      end
      drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d busy after", i), busy, 0);
    end

    // All-thread burst from reset: order 0,1,2,3
    do_reset();
    set_ops(0, 8'd100, 8'd3);
    set_ops(1, 8'd100, 8'd4);
    set_ops(2, 8'd100, 8'd5);
    set_ops(3, 8'd100, 8'd6);
    exp_q.push_back({3'd0, 8'd33});
    exp_q.push_back({3'd1, 8'd25});
    exp_q.push_back({3'd2, 8'd20});
    exp_q.push_back({3'd3, 8'd16});
    s0 = start_cnt;
    @(negedge clk);
    req_valid = '1;
    got_n = 0;
    cyc   = 0;
    while (got_n < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      for (int t = 0; t < THREADS; t++) begin
        if (resp_valid[t]) begin
          req_valid[t] = 1'b0;
          got_n++;
        end
      end
    end
    check("burst responses", got_n, 4);
    check("burst div_start count", start_cnt - s0, 4);
    drain("burst");

    // Held request: no re-grant until dropped for a cycle
    do_reset();
    set_ops(0, 8'd10, 8'd2);
    exp_q.push_back({3'd0, 8'd5});
    @(negedge clk);
    req_valid[0] = 1'b1;
    s0 = start_cnt;
    while (!resp_valid[0] && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("held first resp", resp_valid[0], 1);
    repeat (10) @(negedge clk);
    check("held no regrant starts", start_cnt - s0, 1);
    check("held idle", busy, 0);
    drain("held first");
    req_valid[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b1;
    exp_q.push_back({3'd0, 8'd5});
    wait_resp(0, 30, lat);
    check("held rearm latency", lat, 5);
    drain("held rearm");

    // Fairness: threads 0 and 3 keep re-requesting
    do_reset();
    set_ops(0, 8'd50, 8'd5);
    set_ops(3, 8'd91, 8'd7);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({3'd0, 8'd10});
      exp_q.push_back({3'd3, 8'd13});
    end
    rem0 = 3;
    rem3 = 3;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    cyc = 0;
    while ((rem0 + rem3) > 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (resp_valid[0]) begin
        req_valid[0] = 1'b0;
        rem0--;
      end else if (!req_valid[0] && rem0 > 0) begin
        req_valid[0] = 1'b1;
      end
      if (resp_valid[3]) begin
        req_valid[3] = 1'b0;
        rem3--;
      end else if (!req_valid[3] && rem3 > 0) begin
        req_valid[3] = 1'b1;
      end
    end
    check("fair all served", rem0 + rem3, 0);
    drain("fair");

    // Reset while waiting on the divider
    do_reset();
    set_ops(1, 8'd200, 8'd9);
    @(negedge clk);
    req_valid[1] = 1'b1;
    cyc = 0;
    while (dbg_state != 2'd2 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("reach WAIT", dbg_state, 2);
    reset = 1'b1;
    @(negedge clk);
    check("wrst resp_valid", resp_valid, 0);
    check("wrst resp_result", resp_result, 0);
    check("wrst div_start", div_start, 0);
    check("wrst div_dividend", div_dividend, 0);
    check("wrst div_divisor", div_divisor, 0);
    check("wrst busy", busy, 0);
    reset = 1'b0;
    drain("wrst abort");
    exp_q.push_back({3'd1, 8'd22});
    wait_resp(1, 30, lat);
    check("wrst reissue seen", (lat > 0) ? 1 : 0, 1);
    drain("wrst reissue");

    check("no overlapping div_start", ovl_err, 0);
    check("one resp_valid bit at a time", multi_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
